// File: rtl/exibidor_sequencia.sv
// -----------------------------------------------------------------------------
// exibidor_sequencia
//
// Purpose:
//   Shows the stored memory-game sequence to the player before each round.
//   When started, it walks memory addresses 0..limite. For each address it
//   loads the memory word, lights it on the LEDs for ON_CYCLES, blanks the
//   LEDs for OFF_CYCLES, and then moves on. A single-cycle `pronto` ends the
//   presentation.
//
// Ports:
//   clock         in   1       system clock, rising edge
//   reset         in   1       synchronous, active-low reset
//   iniciar       in   1       start request, honoured only in OCIOSO
//   limite        in   ADDR_W  last address to show, captured on start
//   dado_memoria  in   DATA_W  asynchronous memory read data for `endereco`
//   endereco      out  ADDR_W  address currently being shown (registered)
//   leds          out  DATA_W  latched pattern while in ACENDE, else 0
//   exibindo      out  1       high in every state except OCIOSO and FIM
//   pronto        out  1       one-cycle pulse in FIM
//   som           out  1       buzzer square wave in ACENDE (EXIBE_SOM_EN only)
//   db_estado     out  4       current state code (unused codes read 4'b1001)
//
// Optional feature:
//   EXIBE_SOM_EN  when defined, adds the `som` output and its divider. In
//                 ACENDE, `som` toggles every SOM_DIV cycles, starting at 0.
// -----------------------------------------------------------------------------
module exibidor_sequencia #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500,
  parameter int SOM_DIV    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_memoria,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
`ifdef EXIBE_SOM_EN
  output logic              som,
`endif
  output logic [3:0]        db_estado
);

  // The timer is sized for the largest interval it must count, plus a
  // spare bit, so that no legal parameter value can overflow it.
  localparam int MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_CNT    = (MAX_ON_OFF > SOM_DIV) ? MAX_ON_OFF : SOM_DIV;
  localparam int TW         = $clog2(MAX_CNT) + 1;

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACENDE  = 3'd2,
    APAGA   = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t           estado_q,   estado_d;
  logic [TW-1:0]     timer_q,    timer_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] limite_q,   limite_d;
  logic [DATA_W-1:0] led_q,      led_d;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      timer_q    <= {TW{1'b0}};
      endereco_q <= {ADDR_W{1'b0}};
      limite_q   <= {ADDR_W{1'b0}};
      led_q      <= {DATA_W{1'b0}};
    end else begin
      estado_q   <= estado_d;
      timer_q    <= timer_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      led_q      <= led_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    estado_d   = estado_q;
    timer_d    = timer_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    led_d      = led_q;
    case (estado_q)
      OCIOSO: begin
        endereco_d = {ADDR_W{1'b0}};
        timer_d    = {TW{1'b0}};
        if (iniciar) begin
          estado_d = CARREGA;
          limite_d = limite;
        end else begin
          estado_d = OCIOSO;
        end
      end
      CARREGA: begin
        led_d    = dado_memoria;
        timer_d  = {TW{1'b0}};
        estado_d = ACENDE;
      end
      ACENDE: begin
        if (timer_q == ON_LAST) begin
          timer_d  = {TW{1'b0}};
          estado_d = APAGA;
        end else begin
          timer_d  = timer_q + TW'(1);
        end
      end
      APAGA: begin
        if (timer_q == OFF_LAST) begin
          timer_d = {TW{1'b0}};
          // The last element ends the run, so the address never
          // steps past the captured limit.
          if (endereco_q == limite_q) begin
            estado_d = FIM;
          end else begin
            estado_d = PROXIMO;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PROXIMO: begin
        endereco_d = endereco_q + ADDR_W'(1);
        estado_d   = CARREGA;
      end
      FIM: begin
        endereco_d = {ADDR_W{1'b0}};
        estado_d   = OCIOSO;
      end
      default: begin
        endereco_d = {ADDR_W{1'b0}};
        timer_d    = {TW{1'b0}};
        estado_d   = OCIOSO;
      end
    endcase
  end

  // Moore output decode from the state and registers only.
  always_comb begin
    endereco = endereco_q;
    leds     = {DATA_W{1'b0}};
    exibindo = 1'b1;
    pronto   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        exibindo  = 1'b0;
        db_estado = 4'd0;
      end
      CARREGA: begin
        db_estado = 4'd1;
      end
      ACENDE: begin
        leds      = led_q;
        db_estado = 4'd2;
      end
      APAGA: begin
        db_estado = 4'd3;
      end
      PROXIMO: begin
        db_estado = 4'd4;
      end
      FIM: begin
        exibindo  = 1'b0;
        pronto    = 1'b1;
        db_estado = 4'd5;
      end
      default: begin
        exibindo  = 1'b0;
        db_estado = 4'b1001;
      end
    endcase
  end

`ifdef EXIBE_SOM_EN
  logic [TW-1:0] div_q, div_d;
  logic          som_q, som_d;

  localparam logic [TW-1:0] SOM_LAST = TW'(SOM_DIV - 1);

  // Buzzer divider and square-wave registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q <= {TW{1'b0}};
      som_q <= 1'b0;
    end else begin
      div_q <= div_d;
      som_q <= som_d;
    end
  end

  // The divider runs only while lit; it is re-armed in every other state
  // so that each ACENDE starts with the tone low.
  always_comb begin
    div_d = {TW{1'b0}};
    som_d = 1'b0;
    if (estado_q == ACENDE) begin
      if (div_q == SOM_LAST) begin
        div_d = {TW{1'b0}};
        som_d = ~som_q;
      end else begin
        div_d = div_q + TW'(1);
        som_d = som_q;
      end
    end else begin
      div_d = {TW{1'b0}};
      som_d = 1'b0;
    end
  end

  // The tone is gated by the state so it is silent outside ACENDE.
  always_comb begin
    if (estado_q == ACENDE) begin
      som = som_q;
    end else begin
      som = 1'b0;
    end
  end
`endif

endmodule
